// File: rtl/approx_mult_pipe_if.sv
// Operand/result stream bundle for approx_mult_pipe.
interface approx_mult_pipe_if #(
  parameter int unsigned WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic                 in_mode;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   out_p;
  logic                 out_mode;

  // Operand producer / result consumer side.
  modport master (
    output in_valid, in_a, in_b, in_mode, out_ready,
    input  in_ready, out_valid, out_p, out_mode
  );

  // Multiplier side.
  modport slave (
    input  in_valid, in_a, in_b, in_mode, out_ready,
    output in_ready, out_valid, out_p, out_mode
  );
endinterface

// File: rtl/approx_mult_pipe.sv
// Three-stage unsigned multiplier built from 4x4 tiles; low-weight tiles can be
// approximated per transaction. Keeps a saturating count of approximate beats.
module approx_mult_pipe #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned APPROX_DIAG = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  approx_mult_pipe_if.slave bus,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  approx_cnt
);

  localparam int unsigned N  = WIDTH / 4;
  localparam int unsigned PW = 2 * WIDTH;

  logic             adv;
  logic             accept;

  logic             s1_valid;
  logic             s1_mode;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;

  logic [7:0]       tile_c [N][N];

  logic             s2_valid;
  logic             s2_mode;
  logic [7:0]       s2_tile [N][N];

  logic [PW-1:0]    sum_c;

  logic             s3_valid;
  logic             s3_mode;
  logic [PW-1:0]    s3_p;

  // Whole pipe advances together; a full output register blocks everything.
  assign adv          = !s3_valid || bus.out_ready;
  assign accept       = bus.in_valid && adv;
  assign bus.in_ready = adv;

  assign bus.out_valid = s3_valid;
  assign bus.out_mode  = s3_mode;
  assign bus.out_p     = s3_p;

  // S1: capture operands and mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_mode  <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (adv) begin
      s1_valid <= bus.in_valid;
      s1_mode  <= bus.in_mode;
      s1_a     <= bus.in_a;
      s1_b     <= bus.in_b;
    end
  end

  // Tile array. An approximate tile ORs the two bit-1 partial products and
  // drops their carry, which only differs from exact when both low bit pairs
  // are 2'b11: the tile then reads 2 low (never underflows, minimum is 9).
  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      localparam bit APPROX_TILE = (gi + gj) < int'(APPROX_DIAG);
      logic [3:0] ta;
      logic [3:0] tb;
      logic [7:0] full;
      logic       hit;

      assign ta   = s1_a[4*gi +: 4];
      assign tb   = s1_b[4*gj +: 4];
      assign full = 8'(ta) * 8'(tb);

      if (APPROX_TILE) begin : g_apx
        assign hit = s1_mode && (ta[1:0] == 2'b11) && (tb[1:0] == 2'b11);
      end else begin : g_ext
        assign hit = 1'b0;
      end

      assign tile_c[gi][gj] = full - {6'd0, hit, 1'b0};
    end
  end

  // S2: register every tile result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_mode  <= 1'b0;
      for (int i = 0; i < int'(N); i++) begin
        for (int j = 0; j < int'(N); j++) begin
          s2_tile[i][j] <= '0;
        end
      end
    end else if (adv) begin
      s2_valid <= s1_valid;
      s2_mode  <= s1_mode;
      s2_tile  <= tile_c;
    end
  end

  // Weighted tile sum at full product width.
  always_comb begin
    sum_c = '0;
    for (int i = 0; i < int'(N); i++) begin
      for (int j = 0; j < int'(N); j++) begin
        sum_c = sum_c + (PW'(s2_tile[i][j]) << (4 * (i + j)));
      end
    end
  end

  // S3: output register, held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_valid <= 1'b0;
      s3_mode  <= 1'b0;
      s3_p     <= '0;
    end else if (adv) begin
      s3_valid <= s2_valid;
      s3_mode  <= s2_mode;
      s3_p     <= sum_c;
    end
  end

  // Saturating count of accepted approximate beats; clear has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      approx_cnt <= '0;
    end else if (cnt_clr) begin
      approx_cnt <= '0;
    end else if (accept && bus.in_mode && (approx_cnt != '1)) begin
      approx_cnt <= approx_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_approx_mult_pipe.sv
// Self-checking bench for approx_mult_pipe across several parameter sets.
module tb_approx_mult_pipe;

  localparam int NI = 5;

  typedef struct {
    logic [31:0] p;
    logic        mode;
  } exp_t;

  typedef struct {
    int          k;
    logic [15:0] a;
    logic [15:0] b;
    bit          mode;
    logic [31:0] exp_p;
  } vec_t;

  logic clk;
  logic rst_n;

  logic        drv_valid [NI];
  logic        drv_mode  [NI];
  logic        drv_ordy  [NI];
  logic        drv_clr   [NI];
  logic [15:0] drv_a     [NI];
  logic [15:0] drv_b     [NI];

  logic        mon_valid  [NI];
  logic        mon_iready [NI];
  logic        mon_mode   [NI];
  logic [31:0] mon_p      [NI];
  logic [15:0] mon_cnt    [NI];

  int checks = 0;
  int errors = 0;

  exp_t        q [NI][$];
  int          cnt_m     [NI];
  int          delivered [NI];
  bit          hold      [NI];
  logic [31:0] held_p    [NI];
  logic        held_mode [NI];

  // Instance k: 0 W8 D1 C16, 1 W4 D1 C16, 2 W16 D2 C16, 3 W8 D3 C2, 4 W8 D0 C16.
  function automatic int cfg_w(int k);
    return (k == 1) ? 4 : (k == 2) ? 16 : 8;
  endfunction
  function automatic int cfg_d(int k);
    return (k <= 1) ? 1 : (k == 2) ? 2 : (k == 3) ? 3 : 0;
  endfunction
  function automatic int cfg_c(int k);
    return (k == 3) ? 2 : 16;
  endfunction

  for (genvar k = 0; k < NI; k++) begin : g
    localparam int unsigned W = (k == 1) ? 4 : (k == 2) ? 16 : 8;
    localparam int unsigned D = (k <= 1) ? 1 : (k == 2) ? 2 : (k == 3) ? 3 : 0;
    localparam int unsigned C = (k == 3) ? 2 : 16;

    approx_mult_pipe_if #(.WIDTH(W)) bus ();
    logic [C-1:0] cnt;

    assign bus.in_valid  = drv_valid[k];
    assign bus.in_a      = drv_a[k][W-1:0];
    assign bus.in_b      = drv_b[k][W-1:0];
    assign bus.in_mode   = drv_mode[k];
    assign bus.out_ready = drv_ordy[k];

    assign mon_valid[k]  = bus.out_valid;
    assign mon_iready[k] = bus.in_ready;
    assign mon_mode[k]   = bus.out_mode;
    assign mon_p[k]      = 32'(bus.out_p);
    assign mon_cnt[k]    = 16'(cnt);

    approx_mult_pipe #(.WIDTH(W), .APPROX_DIAG(D), .CNT_W(C)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .cnt_clr    (drv_clr[k]),
      .approx_cnt (cnt)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Product = a*b less 2 at every approximable tile weight whose nibbles both end in 2'b11.
  function automatic logic [31:0] ref_prod(int k, logic [15:0] a, logic [15:0] b, bit mode);
    longint w  = longint'(cfg_w(k));
    longint am = longint'(a) & ((64'sd1 <<< w) - 1);
    longint bm = longint'(b) & ((64'sd1 <<< w) - 1);
    longint p  = am * bm;
    if (mode) begin
      for (int i = 0; i < cfg_w(k) / 4; i++) begin
        for (int j = 0; j < cfg_w(k) / 4; j++) begin
          if ((i + j) < cfg_d(k) && ((am >> (4 * i)) & 3) == 3 && ((bm >> (4 * j)) & 3) == 3)
            p = p - (64'sd2 <<< (4 * (i + j)));
        end
      end
    end
    return 32'(p);
  endfunction

  // Scoreboard: ordering, values, stall stability and counter for every instance.
  task automatic monitor();
    forever begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        if (!rst_n) begin
          q[k].delete();
          cnt_m[k] = 0;
          hold[k]  = 0;
          check($sformatf("rst_out_valid[%0d]", k), 64'(mon_valid[k]), 64'd0);
          continue;
        end
        check($sformatf("approx_cnt[%0d]", k), 64'(mon_cnt[k]), 64'(cnt_m[k]));
        if (hold[k]) begin
          check($sformatf("stall_valid[%0d]", k), 64'(mon_valid[k]), 64'd1);
          check($sformatf("stall_p[%0d]", k), 64'(mon_p[k]), 64'(held_p[k]));
          check($sformatf("stall_mode[%0d]", k), 64'(mon_mode[k]), 64'(held_mode[k]));
        end
        if (mon_valid[k] && drv_ordy[k]) begin
          if (q[k].size() == 0) begin
            check($sformatf("unexpected_out[%0d]", k), 64'd1, 64'd0);
          end else begin
            exp_t e = q[k].pop_front();
            check($sformatf("out_p[%0d]", k), 64'(mon_p[k]), 64'(e.p));
            check($sformatf("out_mode[%0d]", k), 64'(mon_mode[k]), 64'(e.mode));
            delivered[k]++;
          end
        end
        hold[k]      = mon_valid[k] && !drv_ordy[k];
        held_p[k]    = mon_p[k];
        held_mode[k] = mon_mode[k];
        if (drv_valid[k] && mon_iready[k]) begin
          exp_t e;
          e.p    = ref_prod(k, drv_a[k], drv_b[k], drv_mode[k]);
          e.mode = drv_mode[k];
          q[k].push_back(e);
        end
        if (drv_clr[k])
          cnt_m[k] = 0;
        else if (drv_valid[k] && mon_iready[k] && drv_mode[k] && cnt_m[k] != (1 << cfg_c(k)) - 1)
          cnt_m[k] = cnt_m[k] + 1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One isolated beat with a hand-computed result and a latency measurement.
  task automatic run_single(input int k, input logic [15:0] a, input logic [15:0] b,
                            input bit m, input logic [31:0] exp_p, input string name);
    int lat;
    bit seen;
    drv_a[k] = a; drv_b[k] = b; drv_mode[k] = m; drv_valid[k] = 1'b1; drv_ordy[k] = 1'b1;
    @(negedge clk);
    check({name, "_in_ready"}, 64'(mon_iready[k]), 64'd1);
    step();
    drv_valid[k] = 1'b0;
    lat = 0;
    seen = 0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      if (mon_valid[k]) seen = 1;
    end
    check({name, "_latency"}, 64'(lat), 64'd3);
    check({name, "_p"}, 64'(mon_p[k]), 64'(exp_p));
    check({name, "_mode"}, 64'(mon_mode[k]), 64'(m));
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    vec_t vecs[$];
    bit   acc [NI];
    int   accepted;
    int   base;

    vecs.push_back('{0, 16'h0003, 16'h0003, 1'b0, 32'h0000_0009});
    vecs.push_back('{0, 16'h0003, 16'h0003, 1'b1, 32'h0000_0007});
    vecs.push_back('{0, 16'h00FF, 16'h00FF, 1'b0, 32'h0000_FE01});
    vecs.push_back('{0, 16'h00FF, 16'h00FF, 1'b1, 32'h0000_FDFF});
    vecs.push_back('{0, 16'h0033, 16'h0013, 1'b1, 32'h0000_03C7});
    vecs.push_back('{0, 16'h0031, 16'h0033, 1'b1, 32'h0000_09C3});
    // All four tiles approximated: 2 + 2*32 + 512 below exact.
    vecs.push_back('{3, 16'h00FF, 16'h00FF, 1'b1, 32'h0000_FBBF});
    vecs.push_back('{3, 16'h00FF, 16'h00FF, 1'b0, 32'h0000_FE01});
    vecs.push_back('{1, 16'h000F, 16'h000F, 1'b1, 32'h0000_00DF});
    vecs.push_back('{1, 16'h0007, 16'h000B, 1'b1, 32'h0000_004B});
    vecs.push_back('{2, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001});
    vecs.push_back('{2, 16'hFFFF, 16'hFFFF, 1'b1, 32'hFFFD_FFBF});
    vecs.push_back('{4, 16'h00FF, 16'h00FF, 1'b1, 32'h0000_FE01});

    for (int k = 0; k < NI; k++) begin
      drv_valid[k] = 0; drv_mode[k] = 0; drv_ordy[k] = 1; drv_clr[k] = 0;
      drv_a[k] = '0; drv_b[k] = '0; cnt_m[k] = 0; delivered[k] = 0; hold[k] = 0;
      acc[k] = 0;
    end
    rst_n = 1'b0;
    fork
      monitor();
    join_none

    idle(3);
    for (int k = 0; k < NI; k++) begin
      check($sformatf("reset_valid[%0d]", k), 64'(mon_valid[k]), 64'd0);
      check($sformatf("reset_p[%0d]", k), 64'(mon_p[k]), 64'd0);
      check($sformatf("reset_mode[%0d]", k), 64'(mon_mode[k]), 64'd0);
      check($sformatf("reset_cnt[%0d]", k), 64'(mon_cnt[k]), 64'd0);
    end
    #1 rst_n = 1'b1;
    idle(2);

    foreach (vecs[v])
      run_single(vecs[v].k, vecs[v].a, vecs[v].b, vecs[v].mode, vecs[v].exp_p, $sformatf("vec%0d", v));
    check("diag0_counts_approx", 64'(mon_cnt[4]), 64'd1);
    idle(4);

    // Eight back-to-back beats: ready never drops, results emerge consecutively.
    for (int c = 0; c < 11; c++) begin
      drv_valid[0] = (c < 8);
      drv_a[0] = 16'($urandom); drv_b[0] = 16'($urandom); drv_mode[0] = 1'($urandom);
      @(negedge clk);
      if (c < 8) check($sformatf("stream_in_ready_c%0d", c), 64'(mon_iready[0]), 64'd1);
      if (c >= 3) check($sformatf("stream_out_valid_c%0d", c), 64'(mon_valid[0]), 64'd1);
      step();
    end
    drv_valid[0] = 0;
    idle(4);

    // Consumer stalls six cycles while the producer keeps offering beats.
    base = delivered[0];
    accepted = 0;
    drv_ordy[0] = 0;
    drv_valid[0] = 1;
    drv_a[0] = 16'($urandom); drv_b[0] = 16'($urandom); drv_mode[0] = 1'($urandom);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check($sformatf("stall_in_ready_c%0d", c), 64'(mon_iready[0]), 64'(!mon_valid[0]));
      if (mon_iready[0]) accepted++;
      step();
      if (accepted > 0 && accepted <= 3) begin
        drv_a[0] = 16'($urandom); drv_b[0] = 16'($urandom); drv_mode[0] = 1'($urandom);
      end
    end
    check("stall_accepted", 64'(accepted), 64'd3);
    drv_valid[0] = 0;
    drv_ordy[0] = 1;
    idle(8);
    check("stall_delivered", 64'(delivered[0] - base), 64'(accepted));
    check("stall_queue_empty", 64'(q[0].size()), 64'd0);

    // Two-bit counter: clear, saturate, then clear racing an approximate accept.
    drv_clr[3] = 1;
    step();
    drv_clr[3] = 0;
    check("cnt_after_clr", 64'(mon_cnt[3]), 64'd0);
    for (int c = 0; c < 5; c++) begin
      drv_valid[3] = 1; drv_mode[3] = 1; drv_a[3] = 16'($urandom); drv_b[3] = 16'($urandom);
      @(negedge clk);
      check($sformatf("sat_in_ready_c%0d", c), 64'(mon_iready[3]), 64'd1);
      step();
    end
    drv_valid[3] = 0;
    check("cnt_saturated", 64'(mon_cnt[3]), 64'd3);
    drv_clr[3] = 1; drv_valid[3] = 1; drv_mode[3] = 1;
    step();
    drv_clr[3] = 0; drv_valid[3] = 0;
    check("cnt_clr_wins", 64'(mon_cnt[3]), 64'd0);
    idle(5);

    // Reset pulse with three approximate beats in flight.
    for (int c = 0; c < 3; c++) begin
      drv_valid[0] = 1; drv_mode[0] = 1; drv_a[0] = 16'($urandom); drv_b[0] = 16'($urandom);
      @(negedge clk);
      step();
    end
    drv_valid[0] = 0;
    check("pre_reset_valid", 64'(mon_valid[0]), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("reset_now_valid", 64'(mon_valid[0]), 64'd0);
    check("reset_now_cnt", 64'(mon_cnt[0]), 64'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check($sformatf("no_stale_c%0d", c), 64'(mon_valid[0]), 64'd0);
    end
    step();
    run_single(0, 16'h0003, 16'h0003, 1'b1, 32'h0000_0007, "post_reset");

    // Random traffic on every instance with random backpressure and clears.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int k = 0; k < NI; k++) begin
        if (!drv_valid[k] || acc[k]) begin
          drv_valid[k] = ($urandom_range(3) != 0);
          drv_a[k]     = ($urandom_range(7) == 0) ? 16'hFFFF : 16'($urandom);
          drv_b[k]     = ($urandom_range(7) == 0) ? 16'hFFFF : 16'($urandom);
          drv_mode[k]  = 1'($urandom);
        end
        drv_ordy[k] = ($urandom_range(3) != 0);
        drv_clr[k]  = ($urandom_range(49) == 0);
      end
      @(negedge clk);
      for (int k = 0; k < NI; k++) acc[k] = drv_valid[k] && mon_iready[k];
      step();
    end
    for (int k = 0; k < NI; k++) begin
      drv_valid[k] = 0; drv_ordy[k] = 1; drv_clr[k] = 0;
    end
    idle(10);
    for (int k = 0; k < NI; k++)
      check($sformatf("drain_empty[%0d]", k), 64'(q[k].size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
